// File: rtl/id_stage_pipe.sv
// Registered instruction-decode stage for the 16-bit ISA. Decodes one instruction per cycle into an
// output register and stalls on RAW/WAW hazards tracked by an 8-entry pending-write scoreboard.
module id_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int SB_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [15:0]       if_inst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              id_ready,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [4:0]        ex_type,
    output logic [2:0]        ex_sr1,
    output logic [2:0]        ex_sr2,
    output logic [2:0]        ex_dr,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_we,
    output logic [PC_W-1:0]   ex_pc,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr
);

    // Handshakes: a side transfers on a cycle where its valid and ready are both high at the
    // rising edge. fire_in loads the output register; fire_out hands it to execute.

    logic [4:0]        dec_type;
    logic [2:0]        dec_sr1, dec_sr2, dec_dr;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_we, use_sr1, use_sr2;
    logic [DATA_W-1:0] sext5, sext8;

    assign sext5 = {{(DATA_W-5){if_inst[4]}}, if_inst[4:0]};
    assign sext8 = {{(DATA_W-8){if_inst[7]}}, if_inst[7:0]};

    always_comb begin
        dec_type = '0;
        dec_sr1  = '0;
        dec_sr2  = '0;
        dec_dr   = '0;
        dec_imm  = '0;
        dec_we   = 1'b0;
        use_sr1  = 1'b0;
        use_sr2  = 1'b0;
        case (if_inst[15:12])
            4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                dec_dr  = if_inst[11:9];
                dec_sr1 = if_inst[8:6];
                use_sr1 = 1'b1;
                dec_we  = 1'b1;
                if (if_inst[5]) begin
                    dec_type = 5'b00111;
                    dec_imm  = sext5;
                end else begin
                    dec_type = 5'b00110;
                    dec_sr2  = if_inst[2:0];
                    use_sr2  = 1'b1;
                end
            end
            4'h1, 4'h8, 4'h9: begin
                dec_type = 5'b00100;
                dec_sr1  = if_inst[11:9];
                dec_dr   = if_inst[11:9];
                use_sr1  = 1'b1;
                dec_we   = 1'b1;
            end
            4'hA: begin
                dec_type = 5'b00110;
                dec_sr1  = if_inst[8:6];
                dec_sr2  = if_inst[2:0];
                use_sr1  = 1'b1;
                use_sr2  = 1'b1;
            end
            4'hB: begin
                dec_dr = if_inst[11:9];
                dec_we = 1'b1;
                if (if_inst[8]) begin
                    dec_type = 5'b00100;
                    dec_sr1  = if_inst[7:5];
                    use_sr1  = 1'b1;
                end else begin
                    dec_type = 5'b00101;
                    dec_imm  = sext8;
                end
            end
            4'hC, 4'hD: begin
                dec_type = 5'b01001;
                dec_imm  = sext8;
            end
            4'hE: begin
                dec_type = 5'b10001;
                dec_sr1  = if_inst[10:8];
                use_sr1  = 1'b1;
                dec_imm  = sext8;
            end
            default: begin
                dec_type = 5'b10000;
            end
        endcase
    end

    logic              ex_valid_q, ex_valid_d;
    logic [4:0]        ex_type_q, ex_type_d;
    logic [2:0]        ex_sr1_q, ex_sr1_d, ex_sr2_q, ex_sr2_d, ex_dr_q, ex_dr_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic              ex_we_q, ex_we_d;
    logic [PC_W-1:0]   ex_pc_q, ex_pc_d;
    logic [7:0]        pending_q, pending_d;
    logic [7:0]        busy_vec;
    logic              hazard, fire_in, fire_out;

    // A register is busy if a write is outstanding (unless it retires right now) or if the
    // instruction sitting in the output register is about to write it.
    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < 8; r++) begin
            busy_vec[r] = (pending_q[r] & ~(wb_en & (wb_addr == 3'(r))))
                        | (ex_valid_q & ex_we_q & (ex_dr_q == 3'(r)));
        end
        hazard = (SB_EN != 0) & ((use_sr1 & busy_vec[dec_sr1])
                               | (use_sr2 & busy_vec[dec_sr2])
                               | (dec_we  & busy_vec[dec_dr]));
    end

    assign id_ready = ~flush & ~hazard & (~ex_valid_q | ex_ready);
    assign fire_in  = if_valid & id_ready;
    assign fire_out = ex_valid_q & ex_ready;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_type_d  = ex_type_q;
        ex_sr1_d   = ex_sr1_q;
        ex_sr2_d   = ex_sr2_q;
        ex_dr_d    = ex_dr_q;
        ex_imm_d   = ex_imm_q;
        ex_we_d    = ex_we_q;
        ex_pc_d    = ex_pc_q;
        if (fire_in) begin
            ex_valid_d = 1'b1;
            ex_type_d  = dec_type;
            ex_sr1_d   = dec_sr1;
            ex_sr2_d   = dec_sr2;
            ex_dr_d    = dec_dr;
            ex_imm_d   = dec_imm;
            ex_we_d    = dec_we;
            ex_pc_d    = if_pc;
        end else if (fire_out | flush) begin
            ex_valid_d = 1'b0;
        end
    end

    // Set after clear so a same-cycle set and retire of one register leaves it pending.
    // A flushed instruction was never issued, so it reserves nothing.
    always_comb begin
        pending_d = pending_q;
        if (wb_en)
            pending_d[wb_addr] = 1'b0;
        if (fire_out & ~flush & ex_we_q)
            pending_d[ex_dr_q] = 1'b1;
        if (SB_EN == 0)
            pending_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_type_q  <= '0;
            ex_sr1_q   <= '0;
            ex_sr2_q   <= '0;
            ex_dr_q    <= '0;
            ex_imm_q   <= '0;
            ex_we_q    <= 1'b0;
            ex_pc_q    <= '0;
            pending_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_type_q  <= ex_type_d;
            ex_sr1_q   <= ex_sr1_d;
            ex_sr2_q   <= ex_sr2_d;
            ex_dr_q    <= ex_dr_d;
            ex_imm_q   <= ex_imm_d;
            ex_we_q    <= ex_we_d;
            ex_pc_q    <= ex_pc_d;
            pending_q  <= pending_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_type  = ex_type_q;
    assign ex_sr1   = ex_sr1_q;
    assign ex_sr2   = ex_sr2_q;
    assign ex_dr    = ex_dr_q;
    assign ex_imm   = ex_imm_q;
    assign ex_we    = ex_we_q;
    assign ex_pc    = ex_pc_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus a randomized run against a transaction-level
// model (decode table, one-deep output slot, per-register pending bits).
module tb_id_stage_pipe;

    localparam int DW = 32;
    localparam int PW = 16;

    logic          clk;
    logic          rst_n;
    logic          if_valid;
    logic [15:0]   if_inst;
    logic [PW-1:0] if_pc;
    logic          id_ready;
    logic          flush;
    logic          ex_valid;
    logic          ex_ready;
    logic [4:0]    ex_type;
    logic [2:0]    ex_sr1, ex_sr2, ex_dr;
    logic [DW-1:0] ex_imm;
    logic          ex_we;
    logic [PW-1:0] ex_pc;
    logic          wb_en;
    logic [2:0]    wb_addr;
    logic [63:0]   ex_bus;

    int n_checks = 0;
    int n_pass   = 0;

    id_stage_pipe #(.DATA_W(DW), .PC_W(PW), .SB_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_type(ex_type), .ex_sr1(ex_sr1), .ex_sr2(ex_sr2), .ex_dr(ex_dr), .ex_imm(ex_imm),
        .ex_we(ex_we), .ex_pc(ex_pc), .wb_en(wb_en), .wb_addr(wb_addr)
    );

    assign ex_bus = {ex_valid, ex_type, ex_sr1, ex_sr2, ex_dr, ex_imm, ex_we, ex_pc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]    typ;
        logic [2:0]    sr1, sr2, dr;
        logic [DW-1:0] imm;
        logic          we, use1, use2;
        logic [PW-1:0] pc;
    } dec_t;

    // Reference model state
    logic       m_valid;
    dec_t       m_out;
    logic [7:0] m_pend;

    function automatic logic [63:0] mk(input logic [4:0] t, input logic [2:0] s1, input logic [2:0] s2,
                                       input logic [2:0] dr, input logic [DW-1:0] imm, input logic we,
                                       input logic [PW-1:0] pc);
        return {1'b1, t, s1, s2, dr, imm, we, pc};
    endfunction

    function automatic logic [63:0] pack(input dec_t d);
        return {1'b1, d.typ, d.sr1, d.sr2, d.dr, d.imm, d.we, d.pc};
    endfunction

    function automatic logic [DW-1:0] sx(input int v);
        return DW'(v);
    endfunction

    function automatic dec_t ref_decode(input logic [15:0] i, input logic [PW-1:0] pc);
        dec_t d;
        int   op;
        int   imm5, imm8;
        d    = '0;
        d.pc = pc;
        op   = int'(i[15:12]);
        imm5 = int'(i[4:0]) - (i[4] ? 32 : 0);
        imm8 = int'(i[7:0]) - (i[7] ? 256 : 0);
        if (op == 0 || (op >= 2 && op <= 7)) begin
            d.dr = i[11:9]; d.sr1 = i[8:6]; d.use1 = 1; d.we = 1;
            if (i[5]) begin d.typ = 5'b00111; d.imm = sx(imm5); end
            else begin d.typ = 5'b00110; d.sr2 = i[2:0]; d.use2 = 1; end
        end else if (op == 1 || op == 8 || op == 9) begin
            d.typ = 5'b00100; d.sr1 = i[11:9]; d.dr = i[11:9]; d.use1 = 1; d.we = 1;
        end else if (op == 10) begin
            d.typ = 5'b00110; d.sr1 = i[8:6]; d.sr2 = i[2:0]; d.use1 = 1; d.use2 = 1;
        end else if (op == 11) begin
            d.dr = i[11:9]; d.we = 1;
            if (i[8]) begin d.typ = 5'b00100; d.sr1 = i[7:5]; d.use1 = 1; end
            else begin d.typ = 5'b00101; d.imm = sx(imm8); end
        end else if (op == 12 || op == 13) begin
            d.typ = 5'b01001; d.imm = sx(imm8);
        end else if (op == 14) begin
            d.typ = 5'b10001; d.sr1 = i[10:8]; d.use1 = 1; d.imm = sx(imm8);
        end else begin
            d.typ = 5'b10000;
        end
        return d;
    endfunction

    function automatic bit ref_busy(input logic [2:0] r);
        bit retiring = wb_en && (wb_addr == r);
        return (m_pend[r] && !retiring) || (m_valid && m_out.we && m_out.dr == r);
    endfunction

    function automatic bit ref_hazard(input dec_t d);
        return (d.use1 && ref_busy(d.sr1)) || (d.use2 && ref_busy(d.sr2)) || (d.we && ref_busy(d.dr));
    endfunction

    // Drivers
    task automatic idle_inputs();
        if_valid = 0; if_inst = '0; if_pc = '0; flush = 0; ex_ready = 0; wb_en = 0; wb_addr = '0;
    endtask

    task automatic to_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        to_edge();
        to_edge();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        if_valid = 1; if_inst = 16'h0A45; if_pc = 16'h0100; ex_ready = 1;
        to_edge();
        to_edge();
        rst_n = 1; if_valid = 0;
        @(negedge clk);
        n_checks++;
        if (ex_bus !== 64'd0) $display("FAIL reset_outputs: got %h want %h", ex_bus, 64'd0);
        else n_pass++;
        n_checks++;
        if (id_ready !== 1'b1) $display("FAIL reset_id_ready: got %b want 1", id_ready);
        else n_pass++;
    endtask

    task automatic test_alu_decode();
        do_reset();
        if_valid = 1; if_inst = 16'h0A45; if_pc = 16'h0100; ex_ready = 1;
        @(negedge clk);
        n_checks++;
        if (id_ready !== 1'b1) $display("FAIL alu_accept: got %b want 1", id_ready);
        else n_pass++;
        to_edge();
        if_valid = 0;
        @(negedge clk);
        n_checks++;
        if (ex_bus !== mk(5'b00110, 3'd1, 3'd5, 3'd5, '0, 1'b1, 16'h0100))
            $display("FAIL alu_decode: got %h want %h", ex_bus, mk(5'b00110, 3'd1, 3'd5, 3'd5, '0, 1'b1, 16'h0100));
        else n_pass++;
    endtask

    task automatic test_decode_table();
        logic [15:0] insts[7];
        logic [63:0] exps[7];
        insts = '{16'h067F, 16'hB680, 16'hB7A0, 16'hE5F0, 16'hA0C2, 16'hC0FE, 16'h1600};
        exps[0] = mk(5'b00111, 3'd1, 3'd0, 3'd3, 32'hFFFF_FFFF, 1'b1, 16'h0300);
        exps[1] = mk(5'b00101, 3'd0, 3'd0, 3'd3, 32'hFFFF_FF80, 1'b1, 16'h0300);
        exps[2] = mk(5'b00100, 3'd5, 3'd0, 3'd3, 32'h0,         1'b1, 16'h0300);
        exps[3] = mk(5'b10001, 3'd5, 3'd0, 3'd0, 32'hFFFF_FFF0, 1'b0, 16'h0300);
        exps[4] = mk(5'b00110, 3'd3, 3'd2, 3'd0, 32'h0,         1'b0, 16'h0300);
        exps[5] = mk(5'b01001, 3'd0, 3'd0, 3'd0, 32'hFFFF_FFFE, 1'b0, 16'h0300);
        exps[6] = mk(5'b00100, 3'd3, 3'd0, 3'd3, 32'h0,         1'b1, 16'h0300);
        for (int k = 0; k < 7; k++) begin
            do_reset();
            if_valid = 1; if_inst = insts[k]; if_pc = 16'h0300; ex_ready = 1;
            to_edge();
            if_valid = 0;
            @(negedge clk);
            n_checks++;
            if (ex_bus !== exps[k]) $display("FAIL decode_%h: got %h want %h", insts[k], ex_bus, exps[k]);
            else n_pass++;
        end
    endtask

    task automatic test_raw_stall();
        do_reset();
        if_valid = 1; if_inst = 16'hB605; if_pc = 16'h0110; ex_ready = 1;
        to_edge();
        if_inst = 16'h04C1; if_pc = 16'h0112;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (id_ready !== 1'b0) $display("FAIL raw_stall_%0d: got %b want 0", k, id_ready);
            else n_pass++;
            to_edge();
        end
        wb_en = 1; wb_addr = 3'd3;
        @(negedge clk);
        n_checks++;
        if (id_ready !== 1'b1) $display("FAIL raw_release: got %b want 1", id_ready);
        else n_pass++;
        to_edge();
        wb_en = 0; if_valid = 0;
        @(negedge clk);
        n_checks++;
        if (ex_bus !== mk(5'b00110, 3'd3, 3'd1, 3'd2, '0, 1'b1, 16'h0112))
            $display("FAIL raw_issue: got %h want %h", ex_bus, mk(5'b00110, 3'd3, 3'd1, 3'd2, '0, 1'b1, 16'h0112));
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        if_valid = 1; if_inst = 16'h0A45; if_pc = 16'h0200; ex_ready = 0;
        to_edge();
        if_inst = 16'h0240; if_pc = 16'h0202;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (ex_bus !== mk(5'b00110, 3'd1, 3'd5, 3'd5, '0, 1'b1, 16'h0200))
                $display("FAIL hold_out_%0d: got %h want %h", k, ex_bus, mk(5'b00110, 3'd1, 3'd5, 3'd5, '0, 1'b1, 16'h0200));
            else n_pass++;
            n_checks++;
            if (id_ready !== 1'b0) $display("FAIL hold_ready_%0d: got %b want 0", k, id_ready);
            else n_pass++;
            to_edge();
        end
        ex_ready = 1;
        @(negedge clk);
        n_checks++;
        if (id_ready !== 1'b1) $display("FAIL drain_accept: got %b want 1", id_ready);
        else n_pass++;
        to_edge();
        if_valid = 0;
        @(negedge clk);
        n_checks++;
        if (ex_bus !== mk(5'b00110, 3'd1, 3'd0, 3'd1, '0, 1'b1, 16'h0202))
            $display("FAIL back_to_back: got %h want %h", ex_bus, mk(5'b00110, 3'd1, 3'd0, 3'd1, '0, 1'b1, 16'h0202));
        else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        if_valid = 1; if_inst = 16'h0A45; if_pc = 16'h0208; ex_ready = 0;
        to_edge();
        flush = 1; if_inst = 16'h0240; if_pc = 16'h020A;
        @(negedge clk);
        n_checks++;
        if (id_ready !== 1'b0) $display("FAIL flush_block: got %b want 0", id_ready);
        else n_pass++;
        to_edge();
        flush = 0; if_valid = 0;
        @(negedge clk);
        n_checks++;
        if (ex_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", ex_valid);
        else n_pass++;
        if_valid = 1; if_inst = 16'h0A45; if_pc = 16'h0210; ex_ready = 1;
        #1;
        n_checks++;
        if (id_ready !== 1'b1) $display("FAIL flush_no_pending: got %b want 1", id_ready);
        else n_pass++;
        to_edge();
        if_valid = 0;
        @(negedge clk);
        n_checks++;
        if (ex_bus !== mk(5'b00110, 3'd1, 3'd5, 3'd5, '0, 1'b1, 16'h0210))
            $display("FAIL flush_reissue: got %h want %h", ex_bus, mk(5'b00110, 3'd1, 3'd5, 3'd5, '0, 1'b1, 16'h0210));
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        if_valid = 1; if_inst = 16'hB605; if_pc = 16'h0400; ex_ready = 1;
        to_edge();
        if_inst = 16'h04C1; if_pc = 16'h0402;
        to_edge();
        @(negedge clk);
        n_checks++;
        if (id_ready !== 1'b0) $display("FAIL mid_stall_ready: got %b want 0", id_ready);
        else n_pass++;
        rst_n = 0;
        to_edge();
        rst_n = 1; if_valid = 0;
        @(negedge clk);
        n_checks++;
        if (ex_bus !== 64'd0) $display("FAIL mid_stall_reset_out: got %h want %h", ex_bus, 64'd0);
        else n_pass++;
        n_checks++;
        if (id_ready !== 1'b1) $display("FAIL mid_stall_reset_ready: got %b want 1", id_ready);
        else n_pass++;
    endtask

    task automatic test_random(input int cycles);
        dec_t d;
        bit   exp_ready, fin, fout;
        do_reset();
        m_valid = 0; m_out = '0; m_pend = '0;
        for (int c = 0; c < cycles; c++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            if_valid = ($urandom_range(0, 9) < 7);
            if_inst  = 16'($urandom);
            if_pc    = PW'($urandom);
            ex_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 19) == 0);
            wb_en    = ($urandom_range(0, 9) < 3);
            wb_addr  = 3'($urandom_range(0, 7));
            @(negedge clk);
            d = ref_decode(if_inst, if_pc);
            exp_ready = !flush && !ref_hazard(d) && (!m_valid || ex_ready);
            n_checks++;
            if (id_ready !== exp_ready) $display("FAIL rnd_ready c=%0d: got %b want %b", c, id_ready, exp_ready);
            else n_pass++;
            n_checks++;
            if (m_valid) begin
                if (ex_bus !== pack(m_out)) $display("FAIL rnd_out c=%0d: got %h want %h", c, ex_bus, pack(m_out));
                else n_pass++;
            end else begin
                if (ex_valid !== 1'b0) $display("FAIL rnd_valid c=%0d: got %b want 0", c, ex_valid);
                else n_pass++;
            end
            fin  = if_valid && exp_ready;
            fout = m_valid && ex_ready;
            if (!rst_n) begin
                m_valid = 0; m_out = '0; m_pend = '0;
            end else begin
                if (wb_en) m_pend[wb_addr] = 1'b0;
                if (fout && !flush && m_out.we) m_pend[m_out.dr] = 1'b1;
                if (fin) begin m_valid = 1; m_out = d; end
                else if (fout || flush) m_valid = 0;
            end
            to_edge();
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_alu_decode();
        test_decode_table();
        test_raw_stall();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_random(3000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
